// File: rtl/inst_axi_rbridge.sv
// Instruction-side SRAM-like to AXI4 read bridge: every accepted fetch becomes one
// single-beat AR/R transaction, returned to IF in order with exactly one data_ok.

module inst_axi_rbridge_chk #(
    parameter logic [2:0] MAX_CNT = 3'd2
) (
    input logic       clk,
    input logic       resetn,
    input logic [2:0] cnt_q,
    input logic       addr_ok_s,
    input logic       data_ok_s
);
    // Outstanding count stays within 0..MAX_CNT.
    always @(posedge clk) begin
        if (resetn) begin
            assert (cnt_q <= MAX_CNT) else $error("outstanding count above limit");
            assert (!(addr_ok_s && !data_ok_s && cnt_q == MAX_CNT)) else $error("outstanding overflow");
            assert (!(data_ok_s && !addr_ok_s && cnt_q == 3'd0)) else $error("outstanding underflow");
        end
    end
endmodule

module inst_axi_rbridge #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL        = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_err,
    output logic        busy
);
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {AR_IDLE = 1'b0, AR_WAIT = 1'b1} ar_state_e;

    ar_state_e   ar_state_q, ar_state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [1:0]  size_q, size_d;
    logic        arvalid_q, arvalid_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rd_err_q, rd_err_d;
    logic        addr_ok_s, data_ok_s, rready_s;
    logic        unused_s;

    // Single ID, in-order single beats: rid/rlast and the write data path carry no information.
    assign unused_s = ^{rid, rlast, inst_sram_wstrb, inst_sram_wdata};

    // Handshake qualifiers; gated by resetn so nothing is acknowledged while in reset.
    always_comb begin
        addr_ok_s = resetn & (ar_state_q == AR_IDLE) & inst_sram_req & ~inst_sram_wr
                    & (cnt_q < MAX_CNT);
        rready_s  = resetn & (cnt_q != 3'd0);
        data_ok_s = rvalid & rready_s;
    end

    // AR FSM next state plus outstanding counter and sticky error update.
    always_comb begin
        ar_state_d = ar_state_q;
        araddr_d   = araddr_q;
        size_d     = size_q;
        arvalid_d  = arvalid_q;
        cnt_d      = cnt_q;
        rd_err_d   = rd_err_q | (data_ok_s & (rresp != 2'b00));
        case (ar_state_q)
            AR_IDLE: begin
                if (addr_ok_s) begin
                    araddr_d   = inst_sram_addr;
                    size_d     = inst_sram_size;
                    arvalid_d  = 1'b1;
                    ar_state_d = AR_WAIT;
                end else begin
                    arvalid_d  = 1'b0;
                end
            end
            AR_WAIT: begin
                if (arvalid_q && arready) begin
                    arvalid_d  = 1'b0;
                    ar_state_d = AR_IDLE;
                end else begin
                    arvalid_d  = arvalid_q;
                end
            end
            default: begin
                arvalid_d  = 1'b0;
                ar_state_d = AR_IDLE;
            end
        endcase
        case ({addr_ok_s, data_ok_s})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset abandons any in-flight AXI traffic.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_state_q <= AR_IDLE;
            araddr_q   <= 32'd0;
            size_q     <= 2'd0;
            arvalid_q  <= 1'b0;
            cnt_q      <= 3'd0;
            rd_err_q   <= 1'b0;
        end else begin
            ar_state_q <= ar_state_d;
            araddr_q   <= araddr_d;
            size_q     <= size_d;
            arvalid_q  <= arvalid_d;
            cnt_q      <= cnt_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign inst_sram_addr_ok = addr_ok_s;
    assign inst_sram_data_ok = data_ok_s;
    assign inst_sram_rdata   = rdata;
    assign rready            = rready_s;
    assign arid              = ARID_VAL;
    assign araddr            = araddr_q;
    assign arlen             = 8'd0;
    assign arsize            = {1'b0, size_q};
    assign arburst           = 2'b01;
    assign arlock            = 2'b00;
    assign arcache           = 4'd0;
    assign arprot            = 3'd0;
    assign arvalid           = arvalid_q;
    assign rd_err            = rd_err_q;
    assign busy              = (cnt_q != 3'd0) | arvalid_q;

    inst_axi_rbridge_chk #(.MAX_CNT(MAX_CNT)) u_chk (
        .clk       (clk),
        .resetn    (resetn),
        .cnt_q     (cnt_q),
        .addr_ok_s (addr_ok_s),
        .data_ok_s (data_ok_s)
    );
endmodule

// File: doc/inst_axi_rbridge.md
Name: inst_axi_rbridge

Overview:
- Instruction-side slave for the IF stage's SRAM-like fetch interface; converts each accepted fetch into a single-beat AXI4 read (AR/R channels).
- Sits between IF and the top-level AXI crossbar/arbiter.
- Supports up to MAX_OUTSTANDING in-order outstanding fetches.
- Guarantees exactly one data_ok per accepted request, so IF's discard logic never hangs.

Parameters:
MAX_OUTSTANDING, 2, maximum accepted-but-unreturned fetches (1..7)
ARID_VAL, 4'd0, constant ID driven on arid

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
inst_sram_req  in  1  fetch request from IF
inst_sram_wr  in  1  write flag; must be 0, writes never accepted
inst_sram_size  in  2  log2 bytes (2'b10 for fetch)
inst_sram_addr  in  32  fetch address
inst_sram_wstrb  in  4  unused
inst_sram_wdata  in  32  unused
inst_sram_addr_ok  out  1  request accepted this cycle
inst_sram_data_ok  out  1  read data valid this cycle
inst_sram_rdata  out  32  read data
arid  out  4  = ARID_VAL
araddr  out  32  latched request address
arlen  out  8  = 0
arsize  out  3  = {1'b0, latched size}
arburst  out  2  = 2'b01
arlock  out  2  = 0
arcache  out  4  = 0
arprot  out  3  = 0
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  ignored (single ID, in order)
rdata  in  32  read data
rresp  in  2  response code
rlast  in  1  ignored (single beat)
rvalid  in  1  R valid
rready  out  1  R ready
rd_err  out  1  sticky: any rresp != 0 seen since reset
busy  out  1  outstanding count != 0 or arvalid

Behaviour:
- Reset (async, resetn=0): ar_state=AR_IDLE, araddr=0, size_r=0, arvalid=0, cnt=0, rd_err=0.
  - All combinational outputs are gated by resetn: addr_ok=0, data_ok=0, rready=0 while in reset.
  - Outstanding AXI transactions are abandoned; the slave is reset by the same signal.
- AR FSM:
  - AR_IDLE: addr_ok = req & ~wr & (cnt < MAX_OUTSTANDING), combinational.
    - On addr_ok: latch addr/size into araddr/size_r, set arvalid=1 next cycle, go AR_WAIT.
  - AR_WAIT: addr_ok=0. arvalid and araddr held stable until arready. On arvalid&arready: arvalid=0, go AR_IDLE.
  - Peak issue rate is therefore one request per 2 cycles; addr_ok→arvalid latency is 1 cycle.
- Outstanding counter cnt, width 3:
  - +1 on addr_ok; -1 on data_ok.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows (assertion).
- R channel:
  - rready = (cnt != 0).
  - data_ok = rvalid & rready.
  - inst_sram_rdata = rdata, combinational pass-through, zero-latency.
  - rvalid while cnt==0 is not consumed (rready=0); this is a protocol error at the slave.
- Error: on data_ok with rresp != 0, rd_err <= 1 (sticky until reset). data_ok and rdata are still delivered; IF is responsible for ignoring them.
- Writes: wr=1 never sees addr_ok. wstrb/wdata are unused.
- Ordering: responses are returned to IF in request order; a single ARID is used.
- Full: when cnt==MAX_OUTSTANDING, addr_ok=0 even in AR_IDLE. A data_ok in that cycle frees a slot only from the next cycle (addr_ok compares registered cnt).
- Cancel: no cancel input. IF discards stale data itself; the bridge always returns every accepted request.

Test Plan:
1. Single fetch: req=1, addr=0x1c000000, arready=1 → addr_ok in cycle 0; arvalid, araddr=0x1c000000, arsize=3'b010 in cycle 1; rvalid, rdata=0x02800000 in cycle 3 → data_ok=1, rdata=0x02800000, cnt back to 0, busy=0.
2. AR backpressure: arready=0 for 5 cycles → arvalid/araddr stable for all 5 cycles, addr_ok=0 throughout; then arready=1 → FSM returns to AR_IDLE.
3. Full, with MAX_OUTSTANDING=2: two accepted fetches with rvalid held low → third req gets addr_ok=0 until one data_ok occurs; addr_ok then asserts in the following cycle.
4. Simultaneous events: addr_ok and data_ok in the same cycle → cnt unchanged. Two responses 0xAAAA0001 then 0xAAAA0002 arrive → delivered in the same order.
5. Error and write: rresp=2'b10 on a return → data_ok=1 and rd_err=1 stays set. A request with wr=1 → addr_ok stays 0 and no arvalid is issued.
6. Reset mid-operation: resetn dropped while arvalid=1 and cnt=1 → arvalid, cnt, rready, addr_ok and data_ok all go to 0 immediately, without waiting for clk.
